tmds_channel_decoder: RTL and testbench
=======================================

TMDS_CHANNEL_DECODER -- requirements
Module: tmds_channel_decoder

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 8: consecutive control tokens at one offset needed to lock.
REQ-002 SHALL have parameter DWELL, default 1024: maximum cycles without a qualifying control run, in SEARCH or LOCKED, before a 1-step offset advance.
REQ-003 SHALL have port clk_pixel  input  1  pixel clock; the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sym_i  input  10  raw deserialized word, unaligned, bit 0 first on wire, one per cycle.
REQ-006 SHALL have port realign_i  input  1  synchronous pulse forcing SEARCH.
REQ-007 SHALL have port de_o  output  1  data enable; 1 = data_o valid video byte.
REQ-008 SHALL have port data_o  output  8  decoded video byte.
REQ-009 SHALL have port ctrl_o  output  2  {C1,C0} of last control token; held through video.
REQ-010 SHALL have port locked_o  output  1  alignment locked.
REQ-011 SHALL have port offset_o  output  4  current bit offset, 0..9.
REQ-012 SHALL have port lock_lost_o  output  1  one-cycle pulse on LOCKED->SEARCH.

Function
REQ-013 SHALL keep the previous word and form a 20-bit window {sym_i, prev}; aligned symbol = window[offset+9:offset].
REQ-014 SHALL register the aligned symbol (stage 1) and register decoded outputs (stage 2): latency 2 cycles from the word holding the symbol's last bit.
REQ-015 SHALL recognise control tokens 00=10'b1101010100, 01=10'b0010101011, 10=10'b0101010100, 11=10'b1010101011 (q[9:0]).
REQ-016 SHALL decode non-control symbols as: q' = q[9] ? ~q[7:0] : q[7:0]; d[0]=q'[0]; d[i]=q'[i]^q'[i-1] if q[8]=1, else ~(q'[i]^q'[i-1]), i=1..7.
REQ-017 SHALL keep a run counter: +1 per control token at current offset, saturating at LOCK_COUNT; cleared by any non-control symbol or offset change.
REQ-018 SHALL keep a dwell counter: +1 per cycle; cleared when run counter reaches LOCK_COUNT or on offset change.
REQ-019 SHALL implement FSM states SEARCH and LOCKED.
REQ-020 SEARCH: run counter reaching LOCK_COUNT -> LOCKED; locked_o rises the same cycle as the state.
REQ-021 SEARCH: dwell counter reaching DWELL-1 -> offset = (offset+1) mod 10 (9 wraps to 0); counters cleared; remain SEARCH.
REQ-022 LOCKED: dwell counter reaching DWELL-1 -> SEARCH, offset+1 mod 10, lock_lost_o pulses 1 cycle.
REQ-023 LOCKED: non-control symbols SHALL NOT by themselves drop lock.
REQ-024 realign_i=1 in any state -> SEARCH, offset unchanged, counters cleared; lock_lost_o pulses only if it was LOCKED.
REQ-025 realign_i coincident with a dwell expiry: realign wins, no offset advance.
REQ-026 SHALL hold de_o=0 while not locked; data_o and ctrl_o hold their last values then.
REQ-027 When locked: control token -> de_o=0, ctrl_o updated; other symbol -> de_o=1, data_o per REQ-016.
REQ-028 SHALL keep de_o/data_o/ctrl_o aligned to the stage-2 symbol including across the lock edge (gating uses the stage-1 lock state).

Reset
REQ-029 rst_n=0 SHALL asynchronously force: SEARCH, offset_o=0, counters=0, prev=0, pipeline=0, de_o=0, data_o=0, ctrl_o=0, locked_o=0, lock_lost_o=0.
REQ-030 Mid-operation reset SHALL discard lock; after release, behaviour is identical to power-up.

Verification
REQ-031 Offset 0, 8 x CTRL00 then video byte 8'hA5 encoded -> locked_o=1 after 8th token, de_o=1 data_o=8'hA5 2 cycles after the byte word.
REQ-032 Stream shifted by 7 bits, repeating 858-cycle lines (138 control, 720 video) -> offset_o steps 1..7, lock at offset 7, no further advance while lines continue.
REQ-033 Locked, then 1024 cycles with no control run -> lock_lost_o one pulse, locked_o=0, offset_o+1; at offset 9 wraps to 0.
REQ-034 7 x CTRL11 then one video symbol, repeat -> never locks; offset advances every 1024 cycles.
REQ-035 Locked, CTRL10 -> ctrl_o=2'b10 de_o=0; realign_i pulse -> locked_o=0 next cycle, offset unchanged, relock after 8 tokens.
REQ-036 rst_n low while locked mid-video -> all outputs 0 immediately (no clock); offset_o=0 after release.

Source files
------------

// File: rtl/tmds_channel_decoder.sv
`timescale 1ns/1ps
// TMDS channel decoder: bit-offset search locking on control-token runs, then 10b->8b decode.
// Latency 2 clk_pixel from the aligned window to de_o/data_o/ctrl_o; no backpressure, one word per cycle.
module tmds_channel_decoder #(
    parameter int LOCK_COUNT = 8,
    parameter int DWELL      = 1024
) (
    input  logic       clk_pixel,
    input  logic       rst_n,
    input  logic [9:0] sym_i,
    input  logic       realign_i,
    output logic       de_o,
    output logic [7:0] data_o,
    output logic [1:0] ctrl_o,
    output logic       locked_o,
    output logic [3:0] offset_o,
    output logic       lock_lost_o
);
    localparam int RW = $clog2(LOCK_COUNT + 1);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [RW-1:0] RUN_FULL  = RW'(LOCK_COUNT);
    localparam logic [DW-1:0] DWELL_END = DW'(DWELL - 1);

    typedef enum logic {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} state_t;

    // Returns {is_ctrl, C1, C0}.
    function automatic logic [2:0] classify(input logic [9:0] q);
        case (q)
            10'b1101010100: classify = 3'b100;
            10'b0010101011: classify = 3'b101;
            10'b0101010100: classify = 3'b110;
            10'b1010101011: classify = 3'b111;
            default:        classify = 3'b000;
        endcase
    endfunction

    state_t          r_state;
    logic [3:0]      r_offset;
    logic [RW-1:0]   r_run;
    logic [DW-1:0]   r_dwell;
    logic            r_locked;
    logic            r_lost;
    logic [9:0]      r_prev;
    logic [9:0]      r_s1_sym;
    logic [2:0]      r_s1_cls;
    logic            r_de;
    logic [7:0]      r_data;
    logic [1:0]      r_ctrl;

    logic [18:0]     w_window;
    logic [9:0]      w_sym;
    logic [2:0]      w_cls;
    logic [RW-1:0]   w_run_nxt;
    logic            w_run_full;
    logic [7:0]      w_qp;
    logic [7:0]      w_dec;

    // The top bit of sym_i can never land inside a 10-bit slice at offsets 0..9.
    assign w_window = {sym_i[8:0], r_prev};

    always_comb begin
        w_sym = w_window[9:0];
        for (int i = 1; i < 10; i++) begin
            if (r_offset == 4'(i)) w_sym = w_window[i +: 10];
        end
    end

    assign w_cls      = classify(w_sym);
    assign w_run_nxt  = !w_cls[2] ? '0 : (r_run == RUN_FULL) ? r_run : r_run + RW'(1);
    assign w_run_full = (w_run_nxt == RUN_FULL);

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_SEARCH;
            r_offset <= 4'd0;
            r_run    <= '0;
            r_dwell  <= '0;
            r_locked <= 1'b0;
            r_lost   <= 1'b0;
        end else begin
            r_lost <= 1'b0;
            if (realign_i) begin
                r_state  <= ST_SEARCH;
                r_run    <= '0;
                r_dwell  <= '0;
                r_locked <= 1'b0;
                r_lost   <= (r_state == ST_LOCKED);
            end else begin
                r_run <= w_run_nxt;
                if (w_run_full) begin
                    r_dwell  <= '0;
                    r_state  <= ST_LOCKED;
                    r_locked <= 1'b1;
                end else if (r_dwell == DWELL_END) begin
                    r_offset <= (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
                    r_run    <= '0;
                    r_dwell  <= '0;
                    r_state  <= ST_SEARCH;
                    r_locked <= 1'b0;
                    r_lost   <= (r_state == ST_LOCKED);
                end else begin
                    r_dwell <= r_dwell + DW'(1);
                end
            end
        end
    end

    always_comb begin
        w_qp     = r_s1_sym[9] ? ~r_s1_sym[7:0] : r_s1_sym[7:0];
        w_dec    = '0;
        w_dec[0] = w_qp[0];
        for (int i = 1; i < 8; i++) begin
            w_dec[i] = r_s1_sym[8] ? (w_qp[i] ^ w_qp[i-1]) : ~(w_qp[i] ^ w_qp[i-1]);
        end
    end

    // r_locked changes on the same edge that loads stage 1, so it gates that symbol.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_prev   <= '0;
            r_s1_sym <= '0;
            r_s1_cls <= '0;
            r_de     <= 1'b0;
            r_data   <= '0;
            r_ctrl   <= '0;
        end else begin
            r_prev   <= sym_i;
            r_s1_sym <= w_sym;
            r_s1_cls <= w_cls;
            if (!r_locked) begin
                r_de <= 1'b0;
            end else if (r_s1_cls[2]) begin
                r_de   <= 1'b0;
                r_ctrl <= r_s1_cls[1:0];
            end else begin
                r_de   <= 1'b1;
                r_data <= w_dec;
            end
        end
    end

    assign de_o        = r_de;
    assign data_o      = r_data;
    assign ctrl_o      = r_ctrl;
    assign locked_o    = r_locked;
    assign offset_o    = r_offset;
    assign lock_lost_o = r_lost;
endmodule

// File: tb/tb_tmds_channel_decoder.sv
`timescale 1ns/1ps
// Self-checking bench for tmds_channel_decoder: bit-stream stimulus against a per-cycle reference model.
module tb_tmds_channel_decoder;
    localparam int LOCK = 8;
    localparam int DWELL = 1024;
    localparam logic [9:0] CTRL00 = 10'b1101010100;
    localparam logic [9:0] CTRL10 = 10'b0101010100;
    localparam logic [9:0] CTRL11 = 10'b1010101011;

    logic       clk_pixel = 1'b0;
    logic       rst_n;
    logic [9:0] sym_i;
    logic       realign_i;
    logic       de_o;
    logic [7:0] data_o;
    logic [1:0] ctrl_o;
    logic       locked_o;
    logic [3:0] offset_o;
    logic       lock_lost_o;

    int n_checks = 0;
    int n_pass = 0;

    bit sbits[$];
    logic [9:0] m_prev, p_sym;
    logic [3:0] m_off;
    logic       m_lock, m_lost, m_de, p_lock;
    logic [7:0] m_data;
    logic [1:0] m_ctrl;
    int         m_run, m_dwell;

    tmds_channel_decoder dut (
        .clk_pixel(clk_pixel), .rst_n(rst_n), .sym_i(sym_i), .realign_i(realign_i),
        .de_o(de_o), .data_o(data_o), .ctrl_o(ctrl_o), .locked_o(locked_o),
        .offset_o(offset_o), .lock_lost_o(lock_lost_o)
    );

    always #5 clk_pixel = ~clk_pixel;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "timeout");
    end

    function automatic int tok_of(input logic [9:0] q);
        case (q)
            10'b1101010100: return 0;
            10'b0010101011: return 1;
            10'b0101010100: return 2;
            10'b1010101011: return 3;
            default:        return -1;
        endcase
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] q);
        logic [7:0] qp, d;
        qp = q[9] ? ~q[7:0] : q[7:0];
        d[0] = qp[0];
        for (int i = 1; i < 8; i++) d[i] = q[8] ? (qp[i] ^ qp[i-1]) : ~(qp[i] ^ qp[i-1]);
        return d;
    endfunction

    // Encoder with random XOR/XNOR and inversion choices; never emits a control token.
    function automatic logic [9:0] vid(input logic [7:0] d);
        logic [7:0] qp;
        logic x, inv;
        logic [9:0] q;
        x = 1'($urandom_range(0, 1));
        inv = 1'($urandom_range(0, 1));
        qp[0] = d[0];
        for (int i = 1; i < 8; i++) qp[i] = x ? (d[i] ^ qp[i-1]) : ~(d[i] ^ qp[i-1]);
        q = {inv, x, inv ? ~qp : qp};
        if (tok_of(q) >= 0) q = {~inv, x, inv ? qp : ~qp};
        return q;
    endfunction

    function automatic logic [16:0] dut_vec();
        return {de_o, data_o, ctrl_o, locked_o, offset_o, lock_lost_o};
    endfunction

    function automatic logic [16:0] mdl_vec();
        return {m_de, m_data, m_ctrl, m_lock, m_off, m_lost};
    endfunction

    task automatic push_sym(input logic [9:0] q);
        for (int i = 0; i < 10; i++) sbits.push_back(q[i]);
    endtask

    task automatic push_fill(input int n);
        for (int i = 0; i < n; i++) sbits.push_back(1'b0);
    endtask

    task automatic next_word(output logic [9:0] w);
        for (int i = 0; i < 10; i++) w[i] = sbits.pop_front();
    endtask

    task automatic m_reset();
        m_prev = '0; p_sym = '0; p_lock = 1'b0; m_off = '0; m_lock = 1'b0; m_lost = 1'b0;
        m_de = 1'b0; m_data = '0; m_ctrl = '0; m_run = 0; m_dwell = 0;
        sbits.delete();
    endtask

    // Advances the reference model by one clock, applies the word and waits to the sampling point.
    task automatic step(input logic [9:0] w, input logic re);
        logic [19:0] win;
        logic [9:0] s;
        int tok;
        win = {w, m_prev};
        s = win[m_off +: 10];
        tok = tok_of(s);
        if (p_lock) begin
            if (tok_of(p_sym) >= 0) begin m_de = 1'b0; m_ctrl = 2'(tok_of(p_sym)); end
            else begin m_de = 1'b1; m_data = decode(p_sym); end
        end else m_de = 1'b0;
        m_lost = 1'b0;
        if (re) begin
            m_lost = m_lock; m_lock = 1'b0; m_run = 0; m_dwell = 0;
        end else begin
            m_run = (tok >= 0) ? ((m_run < LOCK) ? m_run + 1 : LOCK) : 0;
            if (m_run == LOCK) begin
                m_dwell = 0; m_lock = 1'b1;
            end else if (m_dwell == DWELL - 1) begin
                m_lost = m_lock; m_lock = 1'b0; m_off = (m_off == 4'd9) ? 4'd0 : m_off + 4'd1;
                m_run = 0; m_dwell = 0;
            end else m_dwell++;
        end
        p_sym = s; p_lock = m_lock; m_prev = w;
        sym_i = w; realign_i = re;
        @(posedge clk_pixel);
        @(negedge clk_pixel);
    endtask

    task automatic do_reset();
        @(negedge clk_pixel);
        rst_n = 1'b0; sym_i = '0; realign_i = 1'b0;
        m_reset();
        repeat (2) @(negedge clk_pixel);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_vec() !== 17'h0) $display("FAIL reset_async got=%h exp=00000", dut_vec());
        else n_pass++;
        do_reset();
        n_checks++;
        if (dut_vec() !== 17'h0) $display("FAIL reset_release got=%h exp=00000", dut_vec());
        else n_pass++;
    endtask

    task automatic test_lock_basic();
        logic [9:0] w;
        int k = 0;
        for (int i = 0; i < 8; i++) push_sym(CTRL00);
        push_sym(vid(8'hA5));
        for (int i = 0; i < 4; i++) push_sym(CTRL00);
        while (sbits.size() >= 10) begin
            next_word(w); step(w, 1'b0);
            n_checks++;
            if (dut_vec() !== mdl_vec()) $display("FAIL lock_basic_model cyc=%0d got=%h exp=%h", k, dut_vec(), mdl_vec());
            else n_pass++;
            if (k == 7) begin
                n_checks++;
                if (locked_o !== 1'b0) $display("FAIL lock_basic_early locked=%b exp=0", locked_o); else n_pass++;
            end
            if (k == 8) begin
                n_checks++;
                if (locked_o !== 1'b1) $display("FAIL lock_basic_lock locked=%b exp=1", locked_o); else n_pass++;
            end
            if (k == 10) begin
                n_checks++;
                if ({de_o, data_o} !== {1'b1, 8'hA5}) $display("FAIL lock_basic_byte de=%b data=%h exp de=1 data=a5", de_o, data_o);
                else n_pass++;
            end
            k++;
        end
    endtask

    task automatic test_ctrl_realign();
        logic [9:0] w;
        int k = 0;
        for (int i = 0; i < 3; i++) push_sym(CTRL10);
        for (int i = 0; i < 3; i++) push_sym(vid(8'($urandom)));
        while (sbits.size() >= 10) begin
            next_word(w); step(w, 1'b0);
            n_checks++;
            if (dut_vec() !== mdl_vec()) $display("FAIL ctrl10_model cyc=%0d got=%h exp=%h", k, dut_vec(), mdl_vec());
            else n_pass++;
            if (k == 2) begin
                n_checks++;
                if ({ctrl_o, de_o} !== {2'b10, 1'b0}) $display("FAIL ctrl10_out ctrl=%b de=%b exp ctrl=10 de=0", ctrl_o, de_o);
                else n_pass++;
            end
            k++;
        end
        n_checks++;
        if (locked_o !== 1'b1) $display("FAIL video_keeps_lock locked=%b exp=1", locked_o); else n_pass++;
        step(CTRL00, 1'b1);
        n_checks++;
        if ({locked_o, lock_lost_o, offset_o} !== {1'b0, 1'b1, 4'd0})
            $display("FAIL realign locked=%b lost=%b off=%0d exp locked=0 lost=1 off=0", locked_o, lock_lost_o, offset_o);
        else n_pass++;
        for (int i = 0; i < 10; i++) push_sym(CTRL00);
        k = 0;
        while (sbits.size() >= 10) begin
            next_word(w); step(w, 1'b0);
            n_checks++;
            if (dut_vec() !== mdl_vec()) $display("FAIL relock_model cyc=%0d got=%h exp=%h", k, dut_vec(), mdl_vec());
            else n_pass++;
            if (k == 6 || k == 7) begin
                n_checks++;
                if (locked_o !== (k == 7)) $display("FAIL relock cyc=%0d locked=%b exp=%b", k, locked_o, (k == 7));
                else n_pass++;
            end
            k++;
        end
    endtask

    task automatic test_dwell_loss();
        logic [9:0] w;
        int n_lost = 0;
        for (int i = 0; i < 1100; i++) push_sym(vid(8'($urandom)));
        while (sbits.size() >= 10) begin
            next_word(w); step(w, 1'b0);
            n_checks++;
            if (dut_vec() !== mdl_vec()) $display("FAIL dwell_loss_model got=%h exp=%h", dut_vec(), mdl_vec());
            else n_pass++;
            if (lock_lost_o === 1'b1) n_lost++;
        end
        n_checks++;
        if ({n_lost == 1, locked_o, offset_o} !== {1'b1, 1'b0, 4'd1})
            $display("FAIL dwell_loss pulses=%0d locked=%b off=%0d exp pulses=1 locked=0 off=1", n_lost, locked_o, offset_o);
        else n_pass++;
        push_fill(9);
        for (int ln = 0; ln < 80; ln++) begin
            for (int i = 0; i < 20; i++) push_sym(CTRL00);
            for (int i = 0; i < 100; i++) push_sym(vid(8'($urandom)));
            while (sbits.size() >= 10) begin
                next_word(w); step(w, 1'b0);
                n_checks++;
                if (dut_vec() !== mdl_vec()) $display("FAIL phase9_model got=%h exp=%h", dut_vec(), mdl_vec());
                else n_pass++;
            end
        end
        n_checks++;
        if ({locked_o, offset_o} !== {1'b1, 4'd9}) $display("FAIL phase9_lock locked=%b off=%0d exp locked=1 off=9", locked_o, offset_o);
        else n_pass++;
        n_lost = 0;
        for (int i = 0; i < 1100; i++) push_sym(vid(8'($urandom)));
        while (sbits.size() >= 10) begin
            next_word(w); step(w, 1'b0);
            n_checks++;
            if (dut_vec() !== mdl_vec()) $display("FAIL wrap_model got=%h exp=%h", dut_vec(), mdl_vec());
            else n_pass++;
            if (lock_lost_o === 1'b1) n_lost++;
        end
        n_checks++;
        if ({n_lost == 1, locked_o, offset_o} !== {1'b1, 1'b0, 4'd0})
            $display("FAIL wrap pulses=%0d locked=%b off=%0d exp pulses=1 locked=0 off=0", n_lost, locked_o, offset_o);
        else n_pass++;
    endtask

    task automatic test_realign_vs_dwell();
        do_reset();
        for (int k = 0; k < 2048; k++) begin
            step(10'h000, k == 1023);
            n_checks++;
            if (dut_vec() !== mdl_vec()) $display("FAIL realign_dwell_model cyc=%0d got=%h exp=%h", k, dut_vec(), mdl_vec());
            else n_pass++;
            if (k == 1023 || k == 2046 || k == 2047) begin
                n_checks++;
                if (offset_o !== ((k == 2047) ? 4'd1 : 4'd0) || lock_lost_o !== 1'b0)
                    $display("FAIL realign_dwell cyc=%0d off=%0d lost=%b exp off=%0d lost=0", k, offset_o, lock_lost_o, (k == 2047));
                else n_pass++;
            end
        end
    endtask

    task automatic test_no_lock();
        logic [9:0] w;
        int n_lk = 0;
        do_reset();
        for (int k = 0; k < 2100; k++) begin
            if (sbits.size() < 10) begin
                for (int i = 0; i < 7; i++) push_sym(CTRL11);
                push_sym(vid(8'($urandom)));
            end
            next_word(w); step(w, 1'b0);
            n_checks++;
            if (dut_vec() !== mdl_vec()) $display("FAIL no_lock_model cyc=%0d got=%h exp=%h", k, dut_vec(), mdl_vec());
            else n_pass++;
            if (locked_o !== 1'b0) n_lk++;
            if (k == 1022 || k == 1023 || k == 2047) begin
                n_checks++;
                if (offset_o !== ((k == 1022) ? 4'd0 : (k == 1023) ? 4'd1 : 4'd2))
                    $display("FAIL no_lock_advance cyc=%0d off=%0d", k, offset_o);
                else n_pass++;
            end
        end
        n_checks++;
        if (n_lk != 0) $display("FAIL no_lock_locked cycles_locked=%0d exp=0", n_lk); else n_pass++;
    endtask

    task automatic test_shift7();
        logic [9:0] w;
        logic [3:0] exp_step = 4'd0;
        int n_chg = 0;
        do_reset();
        push_fill(7);
        for (int ln = 0; ln < 12; ln++) begin
            for (int i = 0; i < 138; i++) push_sym(CTRL00);
            for (int i = 0; i < 720; i++) push_sym(vid(8'($urandom)));
            while (sbits.size() >= 10) begin
                next_word(w); step(w, 1'b0);
                n_checks++;
                if (dut_vec() !== mdl_vec()) $display("FAIL shift7_model got=%h exp=%h", dut_vec(), mdl_vec());
                else n_pass++;
                if (offset_o !== exp_step) begin
                    exp_step++; n_chg++;
                    n_checks++;
                    if (offset_o !== exp_step) $display("FAIL shift7_step off=%0d exp=%0d", offset_o, exp_step);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if ({locked_o, offset_o, n_chg == 7} !== {1'b1, 4'd7, 1'b1})
            $display("FAIL shift7_final locked=%b off=%0d steps=%0d exp locked=1 off=7 steps=7", locked_o, offset_o, n_chg);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [9:0] w;
        do_reset();
        for (int i = 0; i < 8; i++) push_sym(CTRL00);
        for (int i = 0; i < 5; i++) push_sym(vid(8'($urandom)));
        while (sbits.size() >= 10) begin
            next_word(w); step(w, 1'b0);
            n_checks++;
            if (dut_vec() !== mdl_vec()) $display("FAIL areset_model got=%h exp=%h", dut_vec(), mdl_vec());
            else n_pass++;
        end
        n_checks++;
        if ({de_o, locked_o} !== 2'b11) $display("FAIL areset_pre de=%b locked=%b exp 1 1", de_o, locked_o); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_vec() !== 17'h0) $display("FAIL areset_now got=%h exp=00000", dut_vec()); else n_pass++;
        m_reset();
        repeat (2) @(negedge clk_pixel);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(CTRL00, 1'b0);
            n_checks++;
            if (dut_vec() !== mdl_vec()) $display("FAIL areset_after cyc=%0d got=%h exp=%h", k, dut_vec(), mdl_vec());
            else n_pass++;
        end
        n_checks++;
        if ({offset_o, locked_o} !== {4'd0, 1'b0}) $display("FAIL areset_state off=%0d locked=%b exp 0 0", offset_o, locked_o);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b1; sym_i = '0; realign_i = 1'b0;
        m_reset();
        test_reset();
        test_lock_basic();
        test_ctrl_realign();
        test_dwell_loss();
        test_realign_vs_dwell();
        test_no_lock();
        test_shift7();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
